// File: rtl/fork_2_l_alu_pkg.sv
// rtl/fork_2_l_alu_pkg.sv - shared opcode constants, state and path-select types for fork_2_l_alu
package fork_2_l_alu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_LD  = 3'd1,
    SEND_ALU = 3'd2,
    RTZ      = 3'd3,
    RTZ_ERR  = 3'd4
  } fork_state_t;

  typedef enum logic {
    PATH_LD  = 1'b0,
    PATH_ALU = 1'b1
  } fork_path_t;

endpackage

// File: rtl/fork_watchdog.sv
// rtl/fork_watchdog.sv - cycle counter that flags expiry after LIMIT enabled cycles
module fork_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the LIMIT-th enabled cycle so the owner reacts on the following edge.
  assign expire = enable && !clear && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/fork_2_l_alu.sv
// rtl/fork_2_l_alu.sv - 4-phase fork routing load / R-type requests to two consumers
// Define FORK_TIMEOUT_EN to add a watchdog on the SEND states.
module fork_2_l_alu
  import fork_2_l_alu_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode,
  input  logic              req_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  output logic              req_out_1,
  input  logic              ack_in_1,
  output logic              req_out_2,
  input  logic              ack_in_2,
  output logic [DATA_W-1:0] data_out,
  output logic              err_opcode,
  output logic              err_timeout
);

  fork_state_t state, state_nxt;
  fork_path_t  path, path_nxt;
  logic        capture;
  logic        err_op_nxt;
  logic        in_send;
  logic        send_acked;
  logic        path_ack;
  logic        timeout_hit;

  assign in_send    = (state == SEND_LD) || (state == SEND_ALU);
  assign send_acked = ((state == SEND_LD) && ack_in_1) || ((state == SEND_ALU) && ack_in_2);
  assign path_ack   = (path == PATH_LD) ? ack_in_1 : ack_in_2;

  always_comb begin
    state_nxt  = state;
    path_nxt   = path;
    capture    = 1'b0;
    err_op_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (req_in) begin
          capture = 1'b1;
          if (opcode == OPC_LOAD) begin
            state_nxt = SEND_LD;
          end else if (opcode == OPC_RTYPE) begin
            state_nxt = SEND_ALU;
          end else begin
            state_nxt  = RTZ_ERR;
            err_op_nxt = 1'b1;
          end
        end
      end
      SEND_LD, SEND_ALU: begin
        // A consumer ack wins over a watchdog expiry landing in the same cycle.
        if (send_acked) begin
          state_nxt = RTZ;
          path_nxt  = (state == SEND_LD) ? PATH_LD : PATH_ALU;
        end else if (timeout_hit) begin
          state_nxt = RTZ_ERR;
        end
      end
      RTZ: begin
        if (!req_in && !path_ack) begin
          state_nxt = IDLE;
        end
      end
      RTZ_ERR: begin
        if (!req_in) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      path       <= PATH_LD;
      data_out   <= '0;
      err_opcode <= 1'b0;
    end else begin
      state      <= state_nxt;
      path       <= path_nxt;
      err_opcode <= err_op_nxt;
      if (capture) begin
        data_out <= data_in;
      end
    end
  end

  assign req_out_1 = (state == SEND_LD);
  assign req_out_2 = (state == SEND_ALU);
  assign ack_out   = (state == RTZ) || (state == RTZ_ERR);

`ifdef FORK_TIMEOUT_EN
  fork_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .enable(in_send),
    .clear (!in_send),
    .expire(timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= in_send && !send_acked && timeout_hit;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign err_timeout        = 1'b0;
  assign unused_timeout_cfg = in_send && (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_fork_2_l_alu.sv
// tb/tb_fork_2_l_alu.sv - directed self-checking bench for fork_2_l_alu
module tb_fork_2_l_alu;

  localparam int DATA_W = 32;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ALU = 7'b0110011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic              clk = 1'b0;
  logic              rst;
  logic [6:0]        opcode;
  logic              req_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic              req_out_1;
  logic              ack_in_1;
  logic              req_out_2;
  logic              ack_in_2;
  logic [DATA_W-1:0] data_out;
  logic              err_opcode;
  logic              err_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fork_2_l_alu #(
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .req_in     (req_in),
    .data_in    (data_in),
    .ack_out    (ack_out),
    .req_out_1  (req_out_1),
    .ack_in_1   (ack_in_1),
    .req_out_2  (req_out_2),
    .ack_in_2   (ack_in_2),
    .data_out   (data_out),
    .err_opcode (err_opcode),
    .err_timeout(err_timeout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Output vector is {req_out_1, req_out_2, ack_out, err_opcode}.
  task automatic test_reset;
    rst = 1'b1; req_in = 1'b0; opcode = '0; data_in = '0; ack_in_1 = 1'b0; ack_in_2 = 1'b0;
    tick(); tick();
    total++;
    if ({req_out_1, req_out_2, ack_out, err_opcode, err_timeout} !== 5'b00000) begin
      bad++; $display("FAIL reset_outputs: got %b want 00000", {req_out_1, req_out_2, ack_out, err_opcode, err_timeout});
    end
    total++;
    if (data_out !== 32'h0) begin
      bad++; $display("FAIL reset_data: got %h want 00000000", data_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load;
    opcode = LD; data_in = 32'hDEADBEEF; req_in = 1'b1;
    tick();
    total++;
    if ({req_out_1, req_out_2, ack_out, err_opcode} !== 4'b1000) begin
      bad++; $display("FAIL load_send: got %b want 1000", {req_out_1, req_out_2, ack_out, err_opcode});
    end
    total++;
    if (data_out !== 32'hDEADBEEF) begin
      bad++; $display("FAIL load_capture: got %h want deadbeef", data_out);
    end
    opcode = ALU; data_in = 32'h11111111;
    tick();
    total++;
    if ({req_out_1, req_out_2, data_out} !== {2'b10, 32'hDEADBEEF}) begin
      bad++; $display("FAIL load_hold: got %b %h want 10 deadbeef", {req_out_1, req_out_2}, data_out);
    end
    ack_in_1 = 1'b1;
    tick();
    total++;
    if ({req_out_1, req_out_2, ack_out, err_opcode} !== 4'b0010) begin
      bad++; $display("FAIL load_rtz: got %b want 0010", {req_out_1, req_out_2, ack_out, err_opcode});
    end
    req_in = 1'b0;
    tick();
    total++;
    if (ack_out !== 1'b1) begin
      bad++; $display("FAIL load_rtz_wait_ack: got %b want 1", ack_out);
    end
    ack_in_1 = 1'b0;
    tick();
    total++;
    if ({req_out_1, req_out_2, ack_out, data_out} !== {3'b000, 32'hDEADBEEF}) begin
      bad++; $display("FAIL load_idle: got %b %h want 000 deadbeef", {req_out_1, req_out_2, ack_out}, data_out);
    end
  endtask

  task automatic test_alu;
    opcode = ALU; data_in = 32'h12345678; req_in = 1'b1;
    tick();
    total++;
    if ({req_out_1, req_out_2, ack_out, data_out} !== {3'b010, 32'h12345678}) begin
      bad++; $display("FAIL alu_send: got %b %h want 010 12345678", {req_out_1, req_out_2, ack_out}, data_out);
    end
    ack_in_1 = 1'b1;
    tick();
    ack_in_1 = 1'b0;
    total++;
    if ({req_out_1, req_out_2, ack_out} !== 3'b010) begin
      bad++; $display("FAIL alu_wrong_ack: got %b want 010", {req_out_1, req_out_2, ack_out});
    end
    ack_in_2 = 1'b1;
    tick();
    total++;
    if ({req_out_1, req_out_2, ack_out} !== 3'b001) begin
      bad++; $display("FAIL alu_rtz: got %b want 001", {req_out_1, req_out_2, ack_out});
    end
    ack_in_2 = 1'b0;
    tick();
    total++;
    if (ack_out !== 1'b1) begin
      bad++; $display("FAIL alu_rtz_wait_req: got %b want 1", ack_out);
    end
    req_in = 1'b0;
    tick();
    total++;
    if ({req_out_1, req_out_2, ack_out} !== 3'b000) begin
      bad++; $display("FAIL alu_idle: got %b want 000", {req_out_1, req_out_2, ack_out});
    end
  endtask

  task automatic test_bad_opcode;
    opcode = BAD; data_in = 32'hA5A5A5A5; req_in = 1'b1;
    tick();
    total++;
    if ({req_out_1, req_out_2, ack_out, err_opcode} !== 4'b0011) begin
      bad++; $display("FAIL bad_entry: got %b want 0011", {req_out_1, req_out_2, ack_out, err_opcode});
    end
    ack_in_1 = 1'b1;
    tick();
    total++;
    if ({req_out_1, req_out_2, ack_out, err_opcode} !== 4'b0010) begin
      bad++; $display("FAIL bad_pulse_once: got %b want 0010", {req_out_1, req_out_2, ack_out, err_opcode});
    end
    req_in = 1'b0;
    tick();
    ack_in_1 = 1'b0;
    total++;
    if ({req_out_1, req_out_2, ack_out, err_opcode} !== 4'b0000) begin
      bad++; $display("FAIL bad_idle: got %b want 0000", {req_out_1, req_out_2, ack_out, err_opcode});
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] exp_req;
      exp_req = (i % 2 == 0) ? 2'b10 : 2'b01;
      opcode  = (i % 2 == 0) ? LD : ALU;
      data_in = 32'h10000000 + 32'(i);
      req_in  = 1'b1;
      tick();
      total++;
      if ({req_out_1, req_out_2, ack_out, data_out} !== {exp_req, 1'b0, 32'h10000000 + 32'(i)}) begin
        bad++; $display("FAIL b2b_send[%0d]: got %b %h want %b0 %h", i, {req_out_1, req_out_2, ack_out}, data_out, exp_req, 32'h10000000 + 32'(i));
      end
      ack_in_1 = exp_req[1];
      ack_in_2 = exp_req[0];
      tick();
      total++;
      if ({req_out_1, req_out_2, ack_out} !== 3'b001) begin
        bad++; $display("FAIL b2b_rtz[%0d]: got %b want 001", i, {req_out_1, req_out_2, ack_out});
      end
      req_in = 1'b0; ack_in_1 = 1'b0; ack_in_2 = 1'b0;
      tick();
      total++;
      if ({req_out_1, req_out_2, ack_out} !== 3'b000) begin
        bad++; $display("FAIL b2b_idle[%0d]: got %b want 000", i, {req_out_1, req_out_2, ack_out});
      end
    end
  endtask

  task automatic test_reset_mid;
    opcode = LD; data_in = 32'hCAFEF00D; req_in = 1'b1;
    tick();
    total++;
    if (req_out_1 !== 1'b1) begin
      bad++; $display("FAIL rstmid_send: got %b want 1", req_out_1);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({req_out_1, req_out_2, ack_out, err_opcode, err_timeout, data_out} !== {5'b00000, 32'h0}) begin
      bad++; $display("FAIL rstmid_clear: got %b %h want 00000 00000000", {req_out_1, req_out_2, ack_out, err_opcode, err_timeout}, data_out);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({req_out_1, req_out_2, ack_out, data_out} !== {3'b100, 32'hCAFEF00D}) begin
      bad++; $display("FAIL rstmid_fresh: got %b %h want 100 cafef00d", {req_out_1, req_out_2, ack_out}, data_out);
    end
    ack_in_1 = 1'b1;
    tick();
    req_in = 1'b0; ack_in_1 = 1'b0;
    tick();
    total++;
    if ({req_out_1, req_out_2, ack_out} !== 3'b000) begin
      bad++; $display("FAIL rstmid_idle: got %b want 000", {req_out_1, req_out_2, ack_out});
    end
  endtask

  task automatic test_timeout;
`ifdef FORK_TIMEOUT_EN
    int n;
    opcode = LD; data_in = 32'h0BADF00D; req_in = 1'b1;
    tick();
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (err_timeout === 1'b1) begin
        n = k;
        break;
      end
    end
    total++;
    if (n !== 10) begin
      bad++; $display("FAIL timeout_latency: got %0d want 10", n);
    end
    total++;
    if ({req_out_1, req_out_2, ack_out} !== 3'b001) begin
      bad++; $display("FAIL timeout_rtz_err: got %b want 001", {req_out_1, req_out_2, ack_out});
    end
    req_in = 1'b0;
    tick();
    total++;
    if ({req_out_1, ack_out, err_timeout} !== 3'b000) begin
      bad++; $display("FAIL timeout_idle: got %b want 000", {req_out_1, ack_out, err_timeout});
    end
`else
    logic seen;
    opcode = ALU; data_in = 32'h0BADF00D; req_in = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      seen = seen | err_timeout;
    end
    total++;
    if ({seen, req_out_2, ack_out} !== 3'b010) begin
      bad++; $display("FAIL no_timeout_wait: got %b want 010", {seen, req_out_2, ack_out});
    end
    ack_in_2 = 1'b1;
    tick();
    req_in = 1'b0; ack_in_2 = 1'b0;
    tick();
    total++;
    if ({req_out_2, ack_out} !== 2'b00) begin
      bad++; $display("FAIL no_timeout_idle: got %b want 00", {req_out_2, ack_out});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_alu();
    test_bad_opcode();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fork_2_l_alu.md
FORK_2_L_ALU -- requirements
Module: fork_2_l_alu

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: watchdog limit in cycles, used only when FORK_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 opcode  input  7  instruction opcode; stable while req_in is high.
REQ-006 req_in  input  1  producer request (4-phase).
REQ-007 data_in  input  DATA_W  payload; stable while req_in is high.
REQ-008 ack_out  output  1  acknowledge to the producer.
REQ-009 req_out_1 / ack_in_1  output / input  1 / 1  load-path handshake (opcode 7'b0000011).
REQ-010 req_out_2 / ack_in_2  output / input  1 / 1  ALU-path handshake (opcode 7'b0110011).
REQ-011 data_out  output  DATA_W  registered payload, shared by both paths.
REQ-012 err_opcode  output  1  one-cycle pulse on an unsupported opcode.
REQ-013 err_timeout  output  1  one-cycle pulse on watchdog expiry; tied to 0 when FORK_TIMEOUT_EN is undefined.

Function
REQ-014 The block SHALL implement five states: IDLE, SEND_LD, SEND_ALU, RTZ and RTZ_ERR.
REQ-015 In IDLE with req_in=1, the block SHALL capture data_in into data_out and decode opcode: load -> SEND_LD; R-type -> SEND_ALU; any other opcode -> RTZ_ERR.
REQ-016 req_out_1 SHALL be high exactly while in SEND_LD, and req_out_2 SHALL be high exactly while in SEND_ALU (Moore outputs), so the first request rises 1 cycle after req_in is sampled.
REQ-017 req_out_1 and req_out_2 SHALL never be high in the same cycle.
REQ-018 In SEND_x with ack_in_x=1, the block SHALL move to RTZ and record the selected path.
REQ-019 An ack on the non-selected path SHALL be ignored.
REQ-020 ack_out SHALL be high exactly while in RTZ or RTZ_ERR.
REQ-021 RTZ SHALL return to IDLE when req_in=0 and the recorded path's ack_in is 0, with both conditions sampled in the same cycle.
REQ-022 On entry to RTZ_ERR, err_opcode SHALL pulse for exactly 1 cycle; RTZ_ERR SHALL return to IDLE when req_in=0, and no downstream request SHALL be issued.
REQ-023 data_out SHALL hold its value from capture until the next capture in IDLE.
REQ-024 A new req_in edge SHALL NOT be accepted until the block has returned to IDLE, giving a minimum 4-cycle transaction (IDLE, SEND, RTZ, IDLE) when every ack is instantaneous.
REQ-025 opcode changes while the block is not in IDLE SHALL have no effect.

Reset
REQ-026 rst=1 SHALL force state=IDLE, req_out_1=0, req_out_2=0, ack_out=0, data_out=0, err_opcode=0, err_timeout=0 and watchdog=0 on the next edge.
REQ-027 Reset mid-transaction SHALL abort it without completing any handshake; after reset, a req_in still high SHALL be treated as a new request.

Configuration
REQ-028 When FORK_TIMEOUT_EN is defined, a counter SHALL run while in SEND_LD or SEND_ALU and clear on any other state.
REQ-029 When that counter reaches TIMEOUT_CYCLES, the block SHALL pulse err_timeout for 1 cycle and go to RTZ_ERR, dropping req_out_x.
REQ-030 When FORK_TIMEOUT_EN is undefined, no counter SHALL exist, err_timeout SHALL be 0, and SEND_x SHALL wait indefinitely.

Structure
REQ-031 A shared package SHALL hold: opcode constants OPC_LOAD and OPC_RTYPE, the state enum fork_state_t, and the path-select enum (PATH_LD, PATH_ALU).
REQ-032 The watchdog SHALL be the sub-module fork_watchdog (enable, clear, expire), instantiated only under FORK_TIMEOUT_EN.
REQ-033 The block SHALL contain no delays, initial blocks or latches, and SHALL be fully synchronous.

Verification
REQ-034 Load route: opcode=0000011, data_in=0xDEADBEEF, req_in=1 -> req_out_1=1 on the next cycle, data_out=0xDEADBEEF, req_out_2 stays 0; ack_in_1=1 -> ack_out=1, req_out_1=0; req_in=0 and ack_in_1=0 -> IDLE.
REQ-035 ALU route: opcode=0110011 -> only req_out_2 rises; ack_in_1 pulsed during SEND_ALU -> no state change.
REQ-036 Bad opcode 1111111 -> err_opcode high 1 cycle, ack_out=1, no req_out; req_in=0 -> IDLE.
REQ-037 Back-to-back: 8 alternating load/ALU transactions with zero-delay acks -> each completes in 4 cycles, no overlap of req_out_1/req_out_2.
REQ-038 Reset in SEND_LD -> all outputs 0 next cycle; with req_in held at 1, a fresh request follows.
REQ-039 FORK_TIMEOUT_EN defined, TIMEOUT_CYCLES=10, ack_in_1 never asserted -> err_timeout pulses 10 cycles after entering SEND_LD, req_out_1 drops, ack_out=1.
